// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: forwarding select codes, default register
// address width and the shadow-stage record used by the hazard unit.
package pipe_ctrl_pkg;

  localparam int AW_DEF = 5;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
  localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand forwarding priority: the youngest in-flight producer (EX) beats
// MEM; x0 and unused sources never match.
module fwd_sel_calc
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  shadow_t          ex_stage,
  input  shadow_t          mem_stage,
  input  logic [AW-1:0]    src,
  input  logic             use_src,
  output logic [SEL_W-1:0] sel,
  output logic             ex_hit
);

  logic src_live;
  logic mem_hit;

  assign src_live = use_src & (src != '0);
  assign ex_hit   = src_live & ex_stage.valid & ex_stage.reg_write & (ex_stage.rd == src);
  assign mem_hit  = src_live & mem_stage.valid & mem_stage.reg_write & (mem_stage.rd == src);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall generator beside the ID/EX register.
// Optional stall counter enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs1,
  input  logic [AW-1:0]       id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  output logic [SEL_W-1:0]    fwd_a_sel,
  output logic [SEL_W-1:0]    fwd_b_sel,
  output logic                stall,
  output logic                ex_bubble,
  output shadow_t [2:0]       shadow_dbg
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_count
`endif
);

  shadow_t          ex_q, mem_q, wb_q;
  shadow_t          id_s;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             ex_hit_a, ex_hit_b;
  logic             kill_id;

  assign id_s = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  fwd_sel_calc #(.AW(AW)) u_calc_a (
    .ex_stage (ex_q),
    .mem_stage(mem_q),
    .src      (id_rs1),
    .use_src  (id_use_rs1),
    .sel      (sel_a),
    .ex_hit   (ex_hit_a)
  );

  fwd_sel_calc #(.AW(AW)) u_calc_b (
    .ex_stage (ex_q),
    .mem_stage(mem_q),
    .src      (id_rs2),
    .use_src  (id_use_rs2),
    .sel      (sel_b),
    .ex_hit   (ex_hit_b)
  );

  // A load in EX cannot forward yet; flush and reset override the stall.
  assign stall   = id_valid & ~flush & ~rst & ex_q.mem_read & (ex_hit_a | ex_hit_b);
  assign kill_id = flush | stall | ~id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      ex_bubble <= 1'b0;
    end else begin
      wb_q      <= mem_q;
      mem_q     <= ex_q;
      ex_q      <= kill_id ? shadow_t'('0) : id_s;
      fwd_a_sel <= kill_id ? FWD_RF : sel_a;
      fwd_b_sel <= kill_id ? FWD_RF : sel_b;
      ex_bubble <= flush | stall;
    end
  end

  assign shadow_dbg = {wb_q, mem_q, ex_q};

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: in-flight instruction model plus
// hand-computed expectations for the named pipeline scenarios.
module tb_fwd_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic          flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, ex_bubble;
  shadow_t [2:0] shadow_dbg;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]   stall_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  fwd_hazard_ctrl #(.AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .ex_bubble   (ex_bubble),
    .shadow_dbg  (shadow_dbg)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
  logic       m_v [3];
  logic [4:0] m_rd[3];
  logic       m_rw[3];
  logic       m_ld[3];
  logic [1:0] m_a, m_b;
  logic       m_bub;
  logic [31:0] m_cnt;

  // Which stage (0 = EX, 1 = MEM) supplies register r, or -1 for the register file.
  function automatic int producer(input logic [4:0] r, input logic u);
    for (int s = 0; s < 2; s++)
      if (u && r != 5'd0 && m_v[s] && m_rw[s] && m_rd[s] == r) return s;
    return -1;
  endfunction

  function automatic logic [1:0] code_of(input int s);
    if (s == 0) return 2'b10;
    if (s == 1) return 2'b01;
    return 2'b00;
  endfunction

  initial begin : model
    logic want_stall;
    int pa, pb;
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 0; m_rd[s] = 0; m_rw[s] = 0; m_ld[s] = 0;
    end
    m_a = 0; m_b = 0; m_bub = 0; m_cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      pa = producer(id_rs1, id_use_rs1);
      pb = producer(id_rs2, id_use_rs2);
      want_stall = id_valid && !flush && !rst && m_ld[0] && (pa == 0 || pb == 0);
      check("m_stall", 32'(stall), 32'(want_stall));
      check("m_ex_bubble", 32'(ex_bubble), 32'(m_bub));
      for (int s = 0; s < 3; s++) check("m_shadow_valid", 32'(shadow_dbg[s].valid), 32'(m_v[s]));
      if (m_v[0]) begin
        check("m_fwd_a", 32'(fwd_a_sel), 32'(m_a));
        check("m_fwd_b", 32'(fwd_b_sel), 32'(m_b));
      end
`ifdef FWD_PERF_CNT_EN
      check("m_stall_count", stall_count, m_cnt);
`endif
      if (rst) begin
        for (int s = 0; s < 3; s++) m_v[s] = 0;
        m_a = 0; m_b = 0; m_bub = 0; m_cnt = 0;
      end else begin
        for (int s = 2; s > 0; s--) begin
          m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_rw[s] = m_rw[s-1]; m_ld[s] = m_ld[s-1];
        end
        if (flush || want_stall || !id_valid) begin
          m_v[0] = 0; m_a = 0; m_b = 0;
        end else begin
          m_v[0] = 1; m_rd[0] = id_rd; m_rw[0] = id_reg_write; m_ld[0] = id_mem_read;
          m_a = code_of(pa); m_b = code_of(pb);
        end
        m_bub = flush || want_stall;
        if (want_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
  end

  // ---------------- driver tasks: inputs change just after the rising edge
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic fl);
    @(posedge clk); #1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = ld; flush = fl;
    @(negedge clk);
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    issue(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs1);
    issue(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic set_rst(input logic val);
    @(posedge clk); #1;
    rst = val; id_valid = 0; flush = 0;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  // scoreboard for hand-computed select pairs {a, b}
  task automatic expect_sel(input logic [1:0] a, input logic [1:0] b);
    exp_q.push_back({a, b});
  endtask

  task automatic check_sel(input string name);
    logic [3:0] e;
    e = exp_q.pop_front();
    check({name, "_a"}, 32'(fwd_a_sel), 32'(e[3:2]));
    check({name, "_b"}, 32'(fwd_b_sel), 32'(e[1:0]));
  endtask

  // ---------------- directed scenarios
  initial begin : stim
`ifdef FWD_PERF_CNT_EN
    logic [31:0] cnt_before;
`endif
    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_sel(2'b00, 2'b00);
    check_sel("reset_sel");
    check("reset_bubble", 32'(ex_bubble), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_valids", {29'd0, shadow_dbg[2].valid, shadow_dbg[1].valid, shadow_dbg[0].valid}, 32'd0);
    set_rst(1'b0);

    // add x5,x1,x2 ; sub x6,x5,x3
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd6, 5'd5, 5'd3);
    check("ex_fwd_stall", 32'(stall), 32'd0);
    nop();
    expect_sel(2'b10, 2'b00);
    check_sel("ex_fwd");
    drain();

    // add x5 ; unrelated ; or x7,x4,x5
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd9, 5'd1, 5'd2);
    alu(5'd7, 5'd4, 5'd5);
    nop();
    expect_sel(2'b00, 2'b01);
    check_sel("mem_fwd");
    drain();

    // operands resolved from different stages
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd6, 5'd1, 5'd2);
    alu(5'd7, 5'd6, 5'd5);
    nop();
    expect_sel(2'b10, 2'b01);
    check_sel("split_fwd");
    drain();

    // lw x5,0(x1) ; add x6,x5,x5
    load(5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd5);
    check("lu_stall", 32'(stall), 32'd1);
    alu(5'd6, 5'd5, 5'd5);
    check("lu_stall_once", 32'(stall), 32'd0);
    check("lu_bubble", 32'(ex_bubble), 32'd1);
    nop();
    expect_sel(2'b01, 2'b01);
    check_sel("lu_sel");
    check("lu_bubble_clear", 32'(ex_bubble), 32'd0);
    drain();

    // x0 producers in MEM and EX, consumer reads x0
    alu(5'd0, 5'd1, 5'd2);
    load(5'd0, 5'd1);
    alu(5'd8, 5'd0, 5'd0);
    check("x0_stall", 32'(stall), 32'd0);
    nop();
    expect_sel(2'b00, 2'b00);
    check_sel("x0_sel");
    drain();

    // load-use coincident with flush
    load(5'd5, 5'd1);
`ifdef FWD_PERF_CNT_EN
    cnt_before = stall_count;
`endif
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    check("flush_stall", 32'(stall), 32'd0);
    nop();
    expect_sel(2'b00, 2'b00);
    check_sel("flush_sel");
    check("flush_bubble", 32'(ex_bubble), 32'd1);
`ifdef FWD_PERF_CNT_EN
    check("flush_count", stall_count, cnt_before);
`endif
    drain();

    // two stalls, reset during a hazard, then a third stall
    set_rst(1'b1);
    set_rst(1'b0);
    load(5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd2);
    alu(5'd6, 5'd5, 5'd2);
`ifdef FWD_PERF_CNT_EN
    check("cnt_one", stall_count, 32'd1);
`endif
    drain();
    load(5'd5, 5'd1);
    alu(5'd6, 5'd2, 5'd5);
    alu(5'd6, 5'd2, 5'd5);
`ifdef FWD_PERF_CNT_EN
    check("cnt_two", stall_count, 32'd2);
`endif
    drain();
    load(5'd5, 5'd1);
    @(posedge clk); #1;
    rst = 1;
    id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 5'd6; id_reg_write = 1; id_mem_read = 0; flush = 0;
    @(negedge clk);
    check("rst_mid_stall", 32'(stall), 32'd0);
    set_rst(1'b0);
    check("rst_clears_valids", {29'd0, shadow_dbg[2].valid, shadow_dbg[1].valid, shadow_dbg[0].valid}, 32'd0);
`ifdef FWD_PERF_CNT_EN
    check("cnt_zero", stall_count, 32'd0);
`endif
    load(5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd5);
    check("third_stall", 32'(stall), 32'd1);
    alu(5'd6, 5'd5, 5'd5);
`ifdef FWD_PERF_CNT_EN
    check("cnt_again", stall_count, 32'd1);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
